// File: rtl/comp_icache_pkg.sv
// Shared types and constants for the compressed-instruction cache.
// Combinational only; no latency.
// No flow control of its own.
package comp_pkg;

    localparam int FIELD1_IDX_SIZE = 3;
    localparam int FIELD2_IDX_SIZE = 8;
    localparam int FIELD3_IDX_SIZE = 5;
    localparam int FIELD1_SIZE     = 7;
    localparam int FIELD2_SIZE     = 15;
    localparam int FIELD3_SIZE     = 10;
    localparam int COMP_WIDTH      = FIELD1_IDX_SIZE + FIELD2_IDX_SIZE + FIELD3_IDX_SIZE;

    typedef logic [COMP_WIDTH-1:0] comp_inst_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/comp_icache_if.sv
// Lookup, fill and flush signals between the fetch side and the compressed cache.
// Wires only; no latency.
// Lookups are never stalled; fills are offered until the controller accepts or drops them.
interface comp_icache_if #(parameter int COMP_WIDTH = comp_pkg::COMP_WIDTH);
    logic                  proc_valid;
    logic [31:0]           proc_addr;
    logic                  proc_ready;
    logic                  proc_hit;
    logic [COMP_WIDTH-1:0] proc_rdata;
    logic                  mem_req_valid;
    logic [31:0]           mem_req_addr;
    logic                  mem_req_ready;
    logic [COMP_WIDTH-1:0] mem_req_rdata;
    logic                  mem_req_drop;
    logic                  flush;
    logic                  flush_busy;

    modport master (
        output proc_valid, proc_addr, mem_req_ready, mem_req_rdata, mem_req_drop, flush,
        input  proc_ready, proc_hit, proc_rdata, mem_req_valid, mem_req_addr, flush_busy
    );

    modport slave (
        input  proc_valid, proc_addr, mem_req_ready, mem_req_rdata, mem_req_drop, flush,
        output proc_ready, proc_hit, proc_rdata, mem_req_valid, mem_req_addr, flush_busy
    );
endinterface

// File: rtl/comp_icache_array.sv
// Tag/data/valid storage: one registered read port, one write port, per-line valid clear.
// Read result one cycle after rd_en; lu_hit is the same-cycle tag compare.
// No backpressure; a write and a read to one line in a cycle return the old contents.
module comp_icache_array #(
    parameter  int NUM_LINES = 64,
    parameter  int TAGW      = 24,
    parameter  int DW        = 16,
    localparam int IDXW      = $clog2(NUM_LINES)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            rd_en,
    input  logic            rd_mask,
    input  logic [IDXW-1:0] rd_idx,
    input  logic [TAGW-1:0] rd_tag,
    output logic            lu_hit,
    output logic            rd_hit,
    output logic [DW-1:0]   rd_data,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [TAGW-1:0] wr_tag,
    input  logic [DW-1:0]   wr_data,
    input  logic            clr_en,
    input  logic [IDXW-1:0] clr_idx
);
    logic [NUM_LINES-1:0] valid_q;
    logic [TAGW-1:0]      tag_mem  [NUM_LINES];
    logic [DW-1:0]        data_mem [NUM_LINES];
    logic                 rd_take;

    assign lu_hit  = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_take = rd_en && lu_hit && !rd_mask;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            rd_hit  <= 1'b0;
            rd_data <= '0;
        end else begin
            if (clr_en) valid_q[clr_idx] <= 1'b0;
            if (wr_en)  valid_q[wr_idx]  <= 1'b1;
            rd_hit  <= rd_take;
            rd_data <= rd_take ? data_mem[rd_idx] : '0;
        end
    end

    // Payload arrays are qualified by valid_q, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end
endmodule

// File: rtl/comp_icache.sv
// Direct-mapped compressed-instruction cache with a single outstanding fill (stats: COMP_ICACHE_STATS_EN).
// Lookup answers one cycle after proc_valid; flush sweep takes NUM_LINES cycles.
// Lookups never stall; one fill is held on mem_req_* until ready or drop, later misses wait.
module comp_icache
    import comp_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int COMP_WIDTH = comp_pkg::COMP_WIDTH
) (
    input  logic          clk,
    input  logic          resetn,
    comp_icache_if.slave  bus
`ifdef COMP_ICACHE_STATS_EN
    ,
    output logic [31:0]   stat_hits,
    output logic [31:0]   stat_misses
`endif
);
    localparam int IDXW = $clog2(NUM_LINES);
    localparam int TAGW = 30 - IDXW;

    state_t          state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic            clr_en;
    logic            idle;
    logic            lu_hit;
    logic            pend_vld_q;
    logic [31:0]     pend_addr_q;
    logic            retire, wr_en, miss_new;
    logic            ready_q;

    assign idle     = (state_q == IDLE);
    assign retire   = pend_vld_q && idle && (bus.mem_req_ready || bus.mem_req_drop);
    assign wr_en    = pend_vld_q && idle && bus.mem_req_ready;
    assign miss_new = idle && !bus.flush && bus.proc_valid && !lu_hit;

    comp_icache_array #(.NUM_LINES(NUM_LINES), .TAGW(TAGW), .DW(COMP_WIDTH)) u_array (
        .clk     (clk),
        .resetn  (resetn),
        .rd_en   (bus.proc_valid),
        .rd_mask (!idle),
        .rd_idx  (bus.proc_addr[2 +: IDXW]),
        .rd_tag  (bus.proc_addr[31 -: TAGW]),
        .lu_hit  (lu_hit),
        .rd_hit  (bus.proc_hit),
        .rd_data (bus.proc_rdata),
        .wr_en   (wr_en),
        .wr_idx  (pend_addr_q[2 +: IDXW]),
        .wr_tag  (pend_addr_q[31 -: TAGW]),
        .wr_data (bus.mem_req_rdata),
        .clr_en  (clr_en),
        .clr_idx (cnt_q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                clr_en = 1'b1;
                if (bus.flush) begin
                    cnt_d = '0;
                end else if (cnt_q == IDXW'(NUM_LINES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDXW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A miss may reload the slot in the very cycle the old request retires.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            ready_q <= bus.proc_valid;
            if (idle && bus.flush) begin
                pend_vld_q <= 1'b0;
            end else if (miss_new && (!pend_vld_q || retire)) begin
                pend_vld_q  <= 1'b1;
                pend_addr_q <= {bus.proc_addr[31:2], 2'b00};
            end else if (retire) begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    assign bus.proc_ready    = ready_q;
    assign bus.mem_req_valid = pend_vld_q;
    assign bus.mem_req_addr  = pend_addr_q;
    assign bus.flush_busy    = (state_q == FLUSH);

`ifdef COMP_ICACHE_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (ready_q) begin
            if (bus.proc_hit) stat_hits   <= sat_inc(stat_hits);
            else              stat_misses <= sat_inc(stat_misses);
        end
    end
`endif
endmodule

// File: tb/tb_comp_icache.sv
// Directed bench for comp_icache: lookups queue expected responses, a negedge monitor scores them.
module tb_comp_icache;
    import comp_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    comp_icache_if #(.COMP_WIDTH(COMP_WIDTH)) bus ();

`ifdef COMP_ICACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    comp_icache #(.NUM_LINES(64), .COMP_WIDTH(COMP_WIDTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
`ifdef COMP_ICACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    typedef struct packed {
        logic                  hit;
        logic [COMP_WIDTH-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && bus.proc_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=1 required=0");
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_hit", 32'(bus.proc_hit), 32'(mon_e.hit));
                chk("resp_data", 32'(bus.proc_rdata), 32'(mon_e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] a, input logic h, input logic [COMP_WIDTH-1:0] d);
        bus.proc_valid = 1'b1;
        bus.proc_addr  = a;
        exp_q.push_back({h, d});
        tick();
        bus.proc_valid = 1'b0;
    endtask

    task automatic fill(input logic rdy, input logic drp, input logic [COMP_WIDTH-1:0] d);
        bus.mem_req_ready = rdy;
        bus.mem_req_drop  = drp;
        bus.mem_req_rdata = d;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_req_drop  = 1'b0;
    endtask

    task automatic chk_req(input string name, input logic v, input logic [31:0] a);
        chk({name, "_vld"}, 32'(bus.mem_req_valid), 32'(v));
        if (v) chk({name, "_addr"}, bus.mem_req_addr, a);
    endtask

    task automatic chk_reset_outs();
        chk("rst_ready", 32'(bus.proc_ready), 0);
        chk("rst_hit", 32'(bus.proc_hit), 0);
        chk("rst_rdata", 32'(bus.proc_rdata), 0);
        chk("rst_req_vld", 32'(bus.mem_req_valid), 0);
        chk("rst_req_addr", bus.mem_req_addr, 0);
        chk("rst_busy", 32'(bus.flush_busy), 0);
    endtask

    initial begin
        bus.proc_valid    = 1'b0;
        bus.proc_addr     = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_req_drop  = 1'b0;
        bus.mem_req_rdata = '0;
        bus.flush         = 1'b0;
        repeat (2) tick();
        chk_reset_outs();
        resetn = 1'b1;
        tick();

        // First miss opens a request
        lookup(32'h100, 1'b0, 16'h0);
        chk_req("miss_req", 1'b1, 32'h100);

        // Second miss keeps the older request; drop retires without a write
        lookup(32'h200, 1'b0, 16'h0);
        chk_req("keep_old", 1'b1, 32'h100);
        fill(1'b0, 1'b1, 16'hDEAD);
        chk_req("after_drop", 1'b0, 32'h0);
        lookup(32'h100, 1'b0, 16'h0);
        chk_req("rereq", 1'b1, 32'h100);

        // Fill then hit
        fill(1'b1, 1'b0, 16'hA5C3);
        chk_req("after_fill", 1'b0, 32'h0);
        lookup(32'h100, 1'b1, 16'hA5C3);

        // Conflicting tags on index 0
        lookup(32'h200, 1'b0, 16'h0);
        chk_req("conf_req", 1'b1, 32'h200);
        fill(1'b1, 1'b0, 16'h2222);
        lookup(32'h100, 1'b0, 16'h0);
        lookup(32'h200, 1'b1, 16'h2222);
        fill(1'b1, 1'b0, 16'h1111);
        lookup(32'h100, 1'b1, 16'h1111);
        lookup(32'h200, 1'b0, 16'h0);
        chk_req("evict_req", 1'b1, 32'h200);

        // Lookup in the same cycle as its fill sees old contents and rearms the request
        bus.proc_valid    = 1'b1;
        bus.proc_addr     = 32'h200;
        bus.mem_req_ready = 1'b1;
        bus.mem_req_rdata = 16'h3333;
        exp_q.push_back({1'b0, 16'h0});
        tick();
        bus.proc_valid    = 1'b0;
        bus.mem_req_ready = 1'b0;
        chk_req("rw_rearm", 1'b1, 32'h200);
        lookup(32'h200, 1'b1, 16'h3333);

        // Ready and drop together: ready wins
        fill(1'b1, 1'b1, 16'h4444);
        chk_req("both_retire", 1'b0, 32'h0);
        lookup(32'h200, 1'b1, 16'h4444);

        // Ready without an outstanding request is ignored
        fill(1'b1, 1'b0, 16'h5555);
        lookup(32'h200, 1'b1, 16'h4444);

        // Flush: cancels request, 64 busy cycles, everything misses
        lookup(32'h104, 1'b0, 16'h0);
        chk_req("pre_flush", 1'b1, 32'h104);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_busy_on", 32'(bus.flush_busy), 1);
        chk_req("flush_cancel", 1'b0, 32'h0);
        n = 0;
        while (bus.flush_busy && n < 200) begin
            bus.proc_valid = 1'b1;
            bus.proc_addr  = 32'h200;
            exp_q.push_back({1'b0, 16'h0});
            tick();
            n++;
        end
        bus.proc_valid = 1'b0;
        chk("flush_cycles", 32'(n), 64);
        chk_req("post_flush", 1'b0, 32'h0);
        lookup(32'h200, 1'b0, 16'h0);
        lookup(32'h100, 1'b0, 16'h0);
        chk_req("post_flush_req", 1'b1, 32'h200);

        // Flush during flush restarts the sweep
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        repeat (10) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        n = 0;
        while (bus.flush_busy && n < 200) begin
            tick();
            n++;
        end
        chk("restart_cycles", 32'(n), 64);

        // Reset in the middle of a sweep
        lookup(32'h100, 1'b0, 16'h0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        repeat (3) lookup(32'h100, 1'b0, 16'h0);
        bus.proc_valid = 1'b1;
        bus.proc_addr  = 32'h100;
        tick();
        bus.proc_valid = 1'b0;
        resetn = 1'b0;
        #1;
        chk_reset_outs();
        exp_q.delete();
        tick();
        resetn = 1'b1;
        tick();
        lookup(32'h100, 1'b0, 16'h0);
        chk_req("post_rst_req", 1'b1, 32'h100);
        repeat (2) tick();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
